// File: rtl/ratio_detector.sv
// Measures the period of an asynchronous divided clock in ref_clk cycles and flags lock.
// Optional DUTY_MEAS_EN adds a high_time output and folds it into the lock decision.
module ratio_detector #(
  parameter int SIZE     = 8,
  parameter int LOCK_CNT = 2
) (
  input  logic            ref_clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic            div_clk,
  output logic [SIZE-1:0] period,
  output logic            period_vld,
  output logic            locked,
`ifdef DUTY_MEAS_EN
  output logic [SIZE-1:0] high_time,
`endif
  output logic            ovf
);

  localparam int MW = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [MW-1:0]   LOCK_M  = MW'(LOCK_CNT);
  localparam logic [SIZE-1:0] CNT_MAX = '1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM  = 2'd1;
  localparam logic [1:0] MEAS = 2'd2;

  logic [2:0]      sync_q, sync_d;
  logic [1:0]      state_q, state_d;
  logic [SIZE-1:0] cnt_q, cnt_d;
  logic [SIZE-1:0] period_q, period_d;
  logic            vld_q, vld_d;
  logic            locked_q, locked_d;
  logic            ovf_q, ovf_d;
  logic [MW-1:0]   match_q, match_d;
  logic            have_prev_q, have_prev_d;
`ifdef DUTY_MEAS_EN
  logic [SIZE-1:0] hcnt_q, hcnt_d;
  logic [SIZE-1:0] high_q, high_d;
`endif

  logic            rise;
  logic            same;
  logic [MW-1:0]   match_inc;

  // sync_q[1] is the synchronised div_clk; sync_q[2] is its one-cycle history
  assign rise = sync_q[1] & ~sync_q[2];

  always_comb begin
    sync_d      = {sync_q[1:0], div_clk};
    state_d     = state_q;
    cnt_d       = cnt_q;
    period_d    = period_q;
    vld_d       = 1'b0;
    locked_d    = locked_q;
    ovf_d       = ovf_q;
    match_d     = match_q;
    have_prev_d = have_prev_q;
    same        = (cnt_q == period_q);
    match_inc   = (match_q >= LOCK_M) ? LOCK_M : match_q + MW'(1);
`ifdef DUTY_MEAS_EN
    hcnt_d      = hcnt_q;
    high_d      = high_q;
    same        = same && (hcnt_q == high_q);
`endif

    if (!enable) begin
      state_d     = IDLE;
      cnt_d       = '0;
      locked_d    = 1'b0;
      ovf_d       = 1'b0;
      match_d     = '0;
      have_prev_d = 1'b0;
`ifdef DUTY_MEAS_EN
      hcnt_d      = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          state_d     = ARM;
          have_prev_d = 1'b0;
        end
        ARM: begin
          if (rise) begin
            cnt_d   = SIZE'(1);
            state_d = MEAS;
`ifdef DUTY_MEAS_EN
            hcnt_d  = SIZE'(1);
`endif
          end
        end
        MEAS: begin
          if (rise) begin
            period_d    = cnt_q;
            vld_d       = 1'b1;
            cnt_d       = SIZE'(1);
            have_prev_d = 1'b1;
`ifdef DUTY_MEAS_EN
            high_d      = hcnt_q;
            hcnt_d      = SIZE'(1);
`endif
            if (have_prev_q && same) begin
              match_d  = match_inc;
              locked_d = (match_inc == LOCK_M);
            end else begin
              match_d  = '0;
              locked_d = 1'b0;
            end
          end else if (cnt_q == CNT_MAX) begin
            // Period too long to represent: drop it and re-arm on the next rise
            ovf_d       = 1'b1;
            locked_d    = 1'b0;
            match_d     = '0;
            have_prev_d = 1'b0;
            cnt_d       = '0;
            state_d     = ARM;
          end else begin
            cnt_d = cnt_q + SIZE'(1);
`ifdef DUTY_MEAS_EN
            if (hcnt_q != CNT_MAX) hcnt_d = hcnt_q + SIZE'(sync_q[1]);
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge ref_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      period_q    <= '0;
      vld_q       <= 1'b0;
      locked_q    <= 1'b0;
      ovf_q       <= 1'b0;
      match_q     <= '0;
      have_prev_q <= 1'b0;
`ifdef DUTY_MEAS_EN
      hcnt_q      <= '0;
      high_q      <= '0;
`endif
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      vld_q       <= vld_d;
      locked_q    <= locked_d;
      ovf_q       <= ovf_d;
      match_q     <= match_d;
      have_prev_q <= have_prev_d;
`ifdef DUTY_MEAS_EN
      hcnt_q      <= hcnt_d;
      high_q      <= high_d;
`endif
    end
  end

  assign period     = period_q;
  assign period_vld = vld_q;
  assign locked     = locked_q;
  assign ovf        = ovf_q;
`ifdef DUTY_MEAS_EN
  assign high_time  = high_q;
`endif

endmodule

// File: tb/tb_ratio_detector.sv
// Bench for ratio_detector: table of div_clk waveforms plus hand sequences for
// overflow, disable and async reset; a reference model queues expected updates.
module tb_ratio_detector;
  localparam int SIZE = 8;
  localparam int LOCK = 2;
  localparam int MAXV = 255;

  logic ref_clk = 1'b0;
  logic reset_n = 1'b1;
  logic enable  = 1'b0;
  logic div_clk = 1'b0;
  logic [SIZE-1:0] period;
  logic            period_vld;
  logic            locked;
  logic            ovf;
`ifdef DUTY_MEAS_EN
  logic [SIZE-1:0] high_time;
`endif

  ratio_detector #(.SIZE(SIZE), .LOCK_CNT(LOCK)) dut (
    .ref_clk   (ref_clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .div_clk   (div_clk),
    .period    (period),
    .period_vld(period_vld),
    .locked    (locked),
`ifdef DUTY_MEAS_EN
    .high_time (high_time),
`endif
    .ovf       (ovf)
  );

  always #5 ref_clk = ~ref_clk;

  typedef struct {
    logic [SIZE-1:0] p;
    logic            lk;
    logic            ov;
    logic [SIZE-1:0] ht;
  } exp_t;

  typedef struct {
    int              h;
    int              l;
    int              reps;
    logic [SIZE-1:0] exp_p;
    logic            exp_lk;
  } vec_t;

  exp_t q[$];
  vec_t tbl[7];

  int n_checks = 0;
  int n_errors = 0;
  int n_vld    = 0;

  // reference model state
  bit m_armed     = 1'b0;
  bit m_have_prev = 1'b0;
  bit m_ovf       = 1'b0;
  int m_match     = 0;
  int m_prev_p    = 0;
  int m_prev_h    = 0;
  int last_h      = 0;
  int last_l      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge ref_clk);
      #1;
    end
  endtask

  task automatic model_clear();
    m_armed     = 1'b0;
    m_have_prev = 1'b0;
    m_ovf       = 1'b0;
    m_match     = 0;
  endtask

  // A new rising edge of div_clk closes the previous segment's measurement.
  task automatic rise_event();
    int   p;
    bit   same;
    exp_t e;
    if (m_armed) begin
      p = last_h + last_l;
      if (p > MAXV) begin
        m_ovf       = 1'b1;
        m_have_prev = 1'b0;
        m_match     = 0;
      end else begin
        same = (p == m_prev_p);
`ifdef DUTY_MEAS_EN
        same = same && (last_h == m_prev_h);
`endif
        if (m_have_prev && same) m_match = (m_match < LOCK) ? m_match + 1 : LOCK;
        else                     m_match = 0;
        m_have_prev = 1'b1;
        m_prev_p    = p;
        m_prev_h    = last_h;
        e.p  = SIZE'(p);
        e.lk = (m_match == LOCK);
        e.ov = m_ovf;
        e.ht = SIZE'(last_h);
        q.push_back(e);
      end
    end else begin
      m_armed = 1'b1;
    end
    div_clk = 1'b1;
  endtask

  task automatic seg(input int h, input int l);
    rise_event();
    step(h);
    div_clk = 1'b0;
    step(l);
    last_h = h;
    last_l = l;
  endtask

  always @(negedge ref_clk) begin
    exp_t e;
    if (reset_n && period_vld) begin
      n_vld++;
      $display("vld #%0d period=%0d locked=%0d ovf=%0d", n_vld, period, locked, ovf);
      if (q.size() == 0) begin
        check("unexpected_vld", 32'(period_vld), 32'(0));
      end else begin
        e = q.pop_front();
        check("vld_period", 32'(period), 32'(e.p));
        check("vld_locked", 32'(locked), 32'(e.lk));
        check("vld_ovf", 32'(ovf), 32'(e.ov));
`ifdef DUTY_MEAS_EN
        check("vld_high_time", 32'(high_time), 32'(e.ht));
`endif
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{10, 10, 4, 8'd20, 1'b1};
    tbl[1] = '{15, 15, 3, 8'd30, 1'b0};
    tbl[2] = '{15, 15, 2, 8'd30, 1'b1};
    tbl[3] = '{1, 1, 6, 8'd2, 1'b1};
    tbl[4] = '{8, 12, 3, 8'd20, 1'b0};
    tbl[5] = '{200, 55, 3, 8'd255, 1'b0};
    tbl[6] = '{6, 14, 3, 8'd20, 1'b0};

    // reset pulse before the first clock edge
    #2 reset_n = 1'b0;
    #1;
    check("reset_period", 32'(period), 32'(0));
    check("reset_vld", 32'(period_vld), 32'(0));
    check("reset_locked", 32'(locked), 32'(0));
    check("reset_ovf", 32'(ovf), 32'(0));
    #1 reset_n = 1'b1;
    enable = 1'b1;
    step(3);

    for (int r = 0; r < 7; r++) begin
      for (int k = 0; k < tbl[r].reps; k++) seg(tbl[r].h, tbl[r].l);
      $display("row %0d: %0d/%0d x%0d period=%0d locked=%0d", r, tbl[r].h, tbl[r].l,
               tbl[r].reps, period, locked);
      check($sformatf("row%0d_period", r), 32'(period), 32'(tbl[r].exp_p));
      check($sformatf("row%0d_locked", r), 32'(locked), 32'(tbl[r].exp_lk));
      check($sformatf("row%0d_ovf", r), 32'(ovf), 32'(0));
    end

    // overflow: div_clk held low far beyond the counter range
    seg(8, 300);
    check("ovf_set", 32'(ovf), 32'(1));
    check("ovf_unlocked", 32'(locked), 32'(0));
    for (int k = 0; k < 4; k++) seg(8, 8);
    check("ovf_resume_period", 32'(period), 32'(16));
    check("ovf_resume_locked", 32'(locked), 32'(1));
    check("ovf_sticky", 32'(ovf), 32'(1));

    // disable mid-period
    rise_event();
    step(10);
    div_clk = 1'b0;
    step(3);
    enable = 1'b0;
    model_clear();
    step(2);
    check("dis_locked", 32'(locked), 32'(0));
    check("dis_ovf", 32'(ovf), 32'(0));
    check("dis_period_hold", 32'(period), 32'(16));
    step(3);
    enable = 1'b1;
    step(2);
    for (int k = 0; k < 3; k++) seg(10, 10);
    check("reen_period", 32'(period), 32'(20));
    check("reen_locked", 32'(locked), 32'(0));
    for (int k = 0; k < 2; k++) seg(10, 10);
    check("pre_reset_locked", 32'(locked), 32'(1));
    check("pre_reset_drained", q.size(), 0);

    // asynchronous reset between clock edges
    #3 reset_n = 1'b0;
    #1;
    check("areset_period", 32'(period), 32'(0));
    check("areset_locked", 32'(locked), 32'(0));
    check("areset_ovf", 32'(ovf), 32'(0));
    check("areset_vld", 32'(period_vld), 32'(0));
    model_clear();
    #2 reset_n = 1'b1;
    step(2);
    for (int k = 0; k < 5; k++) seg(1, 1);
    step(6);
    check("fast_period", 32'(period), 32'(2));
    check("fast_locked", 32'(locked), 32'(1));
    check("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
